lt24_write_decoder: RTL and testbench
=====================================

Name: lt24_write_decoder

Overview:
- Receiving end of the LT24 parallel write bus that ChessEngine drives.
- Snoops LT24Wr_n/CS_n/RS/Data in the same clock domain and decodes ILI9341-style command/parameter/data writes.
- Emits a per-pixel event (x, y, colour) with window auto-increment, plus command, display-state and frame-complete indications.
- Used as a framebuffer mirror feeder and as a board-level bus checker behind the chess top level.

Parameters:
WIDTH, 240, panel columns; default column window end = WIDTH-1
HEIGHT, 320, panel rows; default page window end = HEIGHT-1
X_BITS, 8, width of pixelX output
Y_BITS, 9, width of pixelY output

Ports:
clock  input  1  system clock; the bus is synchronous to it
globalReset  input  1  asynchronous, active-low reset
LT24Wr_n  input  1  write strobe, active low; a write commits on its rising edge
LT24Rd_n  input  1  read strobe, active low; never legal here
LT24CS_n  input  1  chip select, active low
LT24RS  input  1  0 = command, 1 = data/parameter
LT24Reset_n  input  1  panel hardware reset, active low
LT24Data  input  16  bus data
cmdValid  output  1  one-cycle pulse per command write
cmdCode  output  8  LT24Data[7:0] of the last command
pixelValid  output  1  one-cycle pulse per pixel written
pixelX  output  X_BITS  column of the pixel, truncated
pixelY  output  Y_BITS  row of the pixel, truncated
pixelColour  output  16  RGB565 pixel value
frameDone  output  1  one-cycle pulse on window wrap
displayOn  output  1  1 after DISPON, 0 after DISPOFF/reset
protocolError  output  1  one-cycle pulse on a bus violation

Behaviour:
- Reset (globalReset low, async, or LT24Reset_n sampled low, sync): all pulse outputs 0; cmdCode 0; pixelX/pixelY/pixelColour 0; displayOn 0; state IDLE; windows SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1; param index 0.
- Sampling: every cycle with LT24Wr_n low and LT24CS_n low, register data, RS and wr/cs. Strobe = previous-cycle Wr_n==0 and CS_n==0, and current Wr_n==1. The strobe uses the registered data/RS, so CS_n rising together with Wr_n still commits the write.
- Latency: all outputs are registered one cycle after the strobe cycle. Back-to-back strobes every 2 clocks are supported.
- States: IDLE, CASET, PASET, RAMWR, OTHER.
- Every command strobe (RS=0): pulse cmdValid, set cmdCode, clear param index, then act on the code:
  - 0x2A → CASET
  - 0x2B → PASET
  - 0x2C → RAMWR; cursor set to (SC, SP)
  - 0x29 → displayOn=1, state OTHER
  - 0x28 → displayOn=0, state OTHER
  - 0x01 → soft reset: windows to defaults, displayOn=0, state IDLE
  - anything else → OTHER
- CASET/PASET: parameters are byte LT24Data[7:0], ordered start[15:8], start[7:0], end[15:8], end[7:0]. Bytes are staged, and the window register updates atomically on the 4th byte. A new command before the 4th byte leaves the window unchanged. Parameters after the 4th are ignored.
- RAMWR, each data strobe:
  - pixelValid=1, pixelColour=data, pixelX/pixelY = cursor.
  - Then advance: if x>=EC, x←SC and the y update applies; else x←x+1.
  - y update: if y>=EP, y←SP and frameDone pulses together with this pixel; else y←y+1.
  - Cursor registers are 16-bit, and comparisons use the full 16 bits. With SC>EC every pixel wraps x and advances y.
- Data strobes in IDLE/OTHER: ignored, no error.
- protocolError pulses when LT24Wr_n and LT24Rd_n are both low with CS_n low in the same cycle. Decoding continues regardless.
- A command strobe during RAMWR ends the pixel stream. No pixelValid is produced for the command itself.

Test Plan:
- Reset, then 0x2C plus 3 data words 0xF800, 0x07E0, 0x001F → pixels (0,0), (1,0), (2,0) with those colours, one cycle after each Wr_n rise; cmdValid=1 with cmdCode=0x2C.
- CASET 0,10,0,11; PASET 0,5,0,6; RAMWR with 4 words → (10,5), (11,5), (10,6), (11,6); frameDone only on the 4th; a 5th word → (10,5).
- CASET with only 2 params, then 0x2C and 1 word → pixel at (0,0); window still defaults.
- 0x29 → displayOn=1; 0x01 → displayOn=0 and windows default; LT24Reset_n low mid-RAMWR → next data word ignored until a new 0x2C.
- Wr_n and Rd_n low together with CS_n low → protocolError=1 for one cycle; CS_n rising in the same cycle as Wr_n → write still decoded.
- globalReset asserted mid-stream → all outputs 0 immediately (async); after release, first data word without a command → no pixelValid.

Source files
------------

// File: rtl/lt24_write_decoder_if.sv
// LT24 parallel write bus as seen by a snooping receiver.
// The master drives every bus line; the decoder only observes them.
interface lt24_write_decoder_if;
   logic        LT24Wr_n;
   logic        LT24Rd_n;
   logic        LT24CS_n;
   logic        LT24RS;
   logic        LT24Reset_n;
   logic [15:0] LT24Data;

   modport master (
      output LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24Data
   );

   modport slave (
      input  LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24Data
   );
endinterface

// File: rtl/lt24_write_decoder.sv
// Decodes ILI9341-style command/parameter/pixel writes snooped from the LT24 bus
// into registered pixel, command, display-state and frame-complete events.
module lt24_write_decoder #(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320,
   parameter int X_BITS = 8,
   parameter int Y_BITS = 9
) (
   input  logic                  clock,
   input  logic                  globalReset,
   lt24_write_decoder_if.slave   bus,
   output logic                  cmdValid,
   output logic [7:0]            cmdCode,
   output logic                  pixelValid,
   output logic [X_BITS-1:0]     pixelX,
   output logic [Y_BITS-1:0]     pixelY,
   output logic [15:0]           pixelColour,
   output logic                  frameDone,
   output logic                  displayOn,
   output logic                  protocolError
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CASET = 3'd1,
      S_PASET = 3'd2,
      S_RAMWR = 3'd3,
      S_OTHER = 3'd4
   } state_t;

   localparam logic [15:0] EC_DEFAULT = 16'(WIDTH - 1);
   localparam logic [15:0] EP_DEFAULT = 16'(HEIGHT - 1);

   state_t              state_q, state_d;
   logic                wr_seen_q, wr_seen_d;
   logic [15:0]         data_q, data_d;
   logic                rs_q, rs_d;
   logic [2:0]          param_idx_q, param_idx_d;
   logic [23:0]         stage_q, stage_d;
   logic [15:0]         sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
   logic [15:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic [7:0]          cmd_code_q, cmd_code_d;
   logic                pix_valid_q, pix_valid_d;
   logic [X_BITS-1:0]   pix_x_q, pix_x_d;
   logic [Y_BITS-1:0]   pix_y_q, pix_y_d;
   logic [15:0]         colour_q, colour_d;
   logic                frame_q, frame_d;
   logic                disp_q, disp_d;
   logic                perr_q, perr_d;
   logic                sel_wr_s;
   logic                strobe_s;

   assign sel_wr_s = !bus.LT24Wr_n && !bus.LT24CS_n;
   // Commit on the Wr_n rising edge using the data latched while the strobe was low
   assign strobe_s = wr_seen_q && bus.LT24Wr_n;

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      wr_seen_d   = sel_wr_s;
      data_d      = data_q;
      rs_d        = rs_q;
      param_idx_d = param_idx_q;
      stage_d     = stage_q;
      sc_d        = sc_q;
      ec_d        = ec_q;
      sp_d        = sp_q;
      ep_d        = ep_q;
      cur_x_d     = cur_x_q;
      cur_y_d     = cur_y_q;
      cmd_valid_d = 1'b0;
      cmd_code_d  = cmd_code_q;
      pix_valid_d = 1'b0;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      colour_d    = colour_q;
      frame_d     = 1'b0;
      disp_d      = disp_q;
      perr_d      = sel_wr_s && !bus.LT24Rd_n;

      if (!bus.LT24Reset_n) begin
         state_d     = S_IDLE;
         wr_seen_d   = 1'b0;
         data_d      = 16'd0;
         rs_d        = 1'b0;
         param_idx_d = 3'd0;
         stage_d     = 24'd0;
         sc_d        = 16'd0;
         ec_d        = EC_DEFAULT;
         sp_d        = 16'd0;
         ep_d        = EP_DEFAULT;
         cur_x_d     = 16'd0;
         cur_y_d     = 16'd0;
         cmd_code_d  = 8'd0;
         pix_x_d     = '0;
         pix_y_d     = '0;
         colour_d    = 16'd0;
         disp_d      = 1'b0;
         perr_d      = 1'b0;
      end else begin
         if (sel_wr_s) begin
            data_d = bus.LT24Data;
            rs_d   = bus.LT24RS;
         end else begin
            data_d = data_q;
            rs_d   = rs_q;
         end

         if (strobe_s && !rs_q) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = data_q[7:0];
            param_idx_d = 3'd0;
            case (data_q[7:0])
               8'h2A: state_d = S_CASET;
               8'h2B: state_d = S_PASET;
               8'h2C: begin
                  state_d = S_RAMWR;
                  cur_x_d = sc_q;
                  cur_y_d = sp_q;
               end
               8'h29: begin
                  disp_d  = 1'b1;
                  state_d = S_OTHER;
               end
               8'h28: begin
                  disp_d  = 1'b0;
                  state_d = S_OTHER;
               end
               8'h01: begin
                  sc_d    = 16'd0;
                  ec_d    = EC_DEFAULT;
                  sp_d    = 16'd0;
                  ep_d    = EP_DEFAULT;
                  disp_d  = 1'b0;
                  state_d = S_IDLE;
               end
               default: state_d = S_OTHER;
            endcase
         end else if (strobe_s) begin
            case (state_q)
               S_CASET, S_PASET: begin
                  // Window registers change only when the 4th byte lands; later bytes are dropped
                  case (param_idx_q)
                     3'd0: stage_d[23:16] = data_q[7:0];
                     3'd1: stage_d[15:8]  = data_q[7:0];
                     3'd2: stage_d[7:0]   = data_q[7:0];
                     3'd3: begin
                        if (state_q == S_CASET) begin
                           sc_d = stage_q[23:8];
                           ec_d = {stage_q[7:0], data_q[7:0]};
                        end else begin
                           sp_d = stage_q[23:8];
                           ep_d = {stage_q[7:0], data_q[7:0]};
                        end
                     end
                     default: stage_d = stage_q;
                  endcase
                  if (param_idx_q != 3'd4) begin
                     param_idx_d = param_idx_q + 3'd1;
                  end else begin
                     param_idx_d = param_idx_q;
                  end
               end
               S_RAMWR: begin
                  pix_valid_d = 1'b1;
                  colour_d    = data_q;
                  pix_x_d     = cur_x_q[X_BITS-1:0];
                  pix_y_d     = cur_y_q[Y_BITS-1:0];
                  if (cur_x_q >= ec_q) begin
                     cur_x_d = sc_q;
                     if (cur_y_q >= ep_q) begin
                        cur_y_d = sp_q;
                        frame_d = 1'b1;
                     end else begin
                        cur_y_d = cur_y_q + 16'd1;
                     end
                  end else begin
                     cur_x_d = cur_x_q + 16'd1;
                  end
               end
               default: state_d = state_q;
            endcase
         end else begin
            state_d = state_q;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clock or negedge globalReset) begin
      if (!globalReset) begin
         state_q     <= S_IDLE;
         wr_seen_q   <= 1'b0;
         data_q      <= 16'd0;
         rs_q        <= 1'b0;
         param_idx_q <= 3'd0;
         stage_q     <= 24'd0;
         sc_q        <= 16'd0;
         ec_q        <= EC_DEFAULT;
         sp_q        <= 16'd0;
         ep_q        <= EP_DEFAULT;
         cur_x_q     <= 16'd0;
         cur_y_q     <= 16'd0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= 8'd0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         colour_q    <= 16'd0;
         frame_q     <= 1'b0;
         disp_q      <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_seen_q   <= wr_seen_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         param_idx_q <= param_idx_d;
         stage_q     <= stage_d;
         sc_q        <= sc_d;
         ec_q        <= ec_d;
         sp_q        <= sp_d;
         ep_q        <= ep_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         pix_valid_q <= pix_valid_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         colour_q    <= colour_d;
         frame_q     <= frame_d;
         disp_q      <= disp_d;
         perr_q      <= perr_d;
      end
   end

   assign cmdValid      = cmd_valid_q;
   assign cmdCode       = cmd_code_q;
   assign pixelValid    = pix_valid_q;
   assign pixelX        = pix_x_q;
   assign pixelY        = pix_y_q;
   assign pixelColour   = colour_q;
   assign frameDone     = frame_q;
   assign displayOn     = disp_q;
   assign protocolError = perr_q;

endmodule

// File: tb/tb_lt24_write_decoder.sv
// Scoreboard bench for lt24_write_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT raises a pulse output.
module tb_lt24_write_decoder;

   typedef struct packed {
      logic        cv;
      logic [7:0]  code;
      logic        pv;
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] col;
      logic        fd;
      logic        pe;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmdValid, pixelValid, frameDone, displayOn, protocolError;
   logic [7:0]  cmdCode;
   logic [7:0]  pixelX;
   logic [8:0]  pixelY;
   logic [15:0] pixelColour;

   int n_checks = 0;
   int n_pass   = 0;
   ev_t exp_q[$];

   lt24_write_decoder_if bus ();

   lt24_write_decoder #(.WIDTH(240), .HEIGHT(320), .X_BITS(8), .Y_BITS(9)) dut (
      .clock         (clk),
      .globalReset   (rst_n),
      .bus           (bus),
      .cmdValid      (cmdValid),
      .cmdCode       (cmdCode),
      .pixelValid    (pixelValid),
      .pixelX        (pixelX),
      .pixelY        (pixelY),
      .pixelColour   (pixelColour),
      .frameDone     (frameDone),
      .displayOn     (displayOn),
      .protocolError (protocolError)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic exp_cmd(input logic [7:0] code);
      ev_t e = '0;
      e.cv = 1'b1; e.code = code;
      exp_q.push_back(e);
   endtask

   task automatic exp_pix(input logic [7:0] x, input logic [8:0] y, input logic [15:0] col, input logic fd);
      ev_t e = '0;
      e.pv = 1'b1; e.x = x; e.y = y; e.col = col; e.fd = fd;
      exp_q.push_back(e);
   endtask

   task automatic exp_perr();
      ev_t e = '0;
      e.pe = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic bus_write(input logic rs, input logic [15:0] d, input logic keep_cs);
      @(posedge clk); #1;
      bus.LT24CS_n = 1'b0; bus.LT24Wr_n = 1'b0; bus.LT24RS = rs; bus.LT24Data = d;
      @(posedge clk); #1;
      bus.LT24Wr_n = 1'b1;
      if (!keep_cs) bus.LT24CS_n = 1'b1;
   endtask

   task automatic cmd(input logic [7:0] c);
      exp_cmd(c);
      bus_write(1'b0, {8'h00, c}, 1'b1);
   endtask

   task automatic prm(input logic [7:0] b);
      bus_write(1'b1, {8'h00, b}, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.LT24CS_n = 1'b1;
      end
   endtask

   // Monitor: every pulse output must match the next queued expectation
   always @(negedge clk) begin
      if (rst_n && (cmdValid || pixelValid || frameDone || protocolError)) begin
         ev_t a;
         a.cv   = cmdValid;
         a.code = cmdValid ? cmdCode : 8'h00;
         a.pv   = pixelValid;
         a.x    = pixelValid ? pixelX : 8'h00;
         a.y    = pixelValid ? pixelY : 9'h000;
         a.col  = pixelValid ? pixelColour : 16'h0000;
         a.fd   = frameDone;
         a.pe   = protocolError;
         if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(a), 64'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event", 64'(a), 64'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.LT24Wr_n = 1'b1; bus.LT24Rd_n = 1'b1; bus.LT24CS_n = 1'b1;
      bus.LT24RS = 1'b0; bus.LT24Reset_n = 1'b1; bus.LT24Data = 16'h0000;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_outputs", {32'd0, cmdValid, pixelValid, frameDone, displayOn, protocolError, cmdCode, pixelX},
          64'd0);
      chk("reset_pixel", {pixelY, pixelColour}, 64'd0);

      // Default window stream
      cmd(8'h2C);
      exp_pix(8'd0, 9'd0, 16'hF800, 1'b0); bus_write(1'b1, 16'hF800, 1'b1);
      exp_pix(8'd1, 9'd0, 16'h07E0, 1'b0); bus_write(1'b1, 16'h07E0, 1'b1);
      exp_pix(8'd2, 9'd0, 16'h001F, 1'b0); bus_write(1'b1, 16'h001F, 1'b1);
      idle(2);

      // 2x2 window with frame wrap
      cmd(8'h2A); prm(8'h00); prm(8'h0A); prm(8'h00); prm(8'h0B);
      cmd(8'h2B); prm(8'h00); prm(8'h05); prm(8'h00); prm(8'h06);
      cmd(8'h2C);
      exp_pix(8'd10, 9'd5, 16'h1111, 1'b0); bus_write(1'b1, 16'h1111, 1'b1);
      exp_pix(8'd11, 9'd5, 16'h2222, 1'b0); bus_write(1'b1, 16'h2222, 1'b1);
      exp_pix(8'd10, 9'd6, 16'h3333, 1'b0); bus_write(1'b1, 16'h3333, 1'b1);
      exp_pix(8'd11, 9'd6, 16'h4444, 1'b1); bus_write(1'b1, 16'h4444, 1'b1);
      exp_pix(8'd10, 9'd5, 16'h5555, 1'b0); bus_write(1'b1, 16'h5555, 1'b1);
      idle(2);

      // Soft reset, then an incomplete CASET must not move the window
      cmd(8'h01);
      cmd(8'h2A); prm(8'h00); prm(8'h05);
      cmd(8'h2C);
      exp_pix(8'd0, 9'd0, 16'hABCD, 1'b0); bus_write(1'b1, 16'hABCD, 1'b1);
      exp_pix(8'd1, 9'd0, 16'hBCDE, 1'b0); bus_write(1'b1, 16'hBCDE, 1'b1);
      idle(2);

      // SC > EC: every pixel wraps x; extra CASET byte ignored
      cmd(8'h2A); prm(8'h00); prm(8'h05); prm(8'h00); prm(8'h03); prm(8'hFF);
      cmd(8'h2B); prm(8'h00); prm(8'h00); prm(8'h00); prm(8'h01);
      cmd(8'h2C);
      exp_pix(8'd5, 9'd0, 16'h0A0A, 1'b0); bus_write(1'b1, 16'h0A0A, 1'b1);
      exp_pix(8'd5, 9'd1, 16'h0B0B, 1'b1); bus_write(1'b1, 16'h0B0B, 1'b1);
      exp_pix(8'd5, 9'd0, 16'h0C0C, 1'b0); bus_write(1'b1, 16'h0C0C, 1'b1);
      idle(2);

      // Display on/off and soft reset restoring default windows
      cmd(8'h29); idle(1);
      @(negedge clk); chk("display_on", displayOn, 64'd1);
      cmd(8'h01); idle(1);
      @(negedge clk); chk("display_off_softreset", displayOn, 64'd0);
      cmd(8'h2C);
      exp_pix(8'd0, 9'd0, 16'h7777, 1'b0); bus_write(1'b1, 16'h7777, 1'b1);
      exp_pix(8'd1, 9'd0, 16'h8888, 1'b0); bus_write(1'b1, 16'h8888, 1'b1);
      idle(2);

      // Panel reset mid-RAMWR: next data ignored until a new RAMWR
      @(posedge clk); #1 bus.LT24Reset_n = 1'b0;
      @(posedge clk); #1 bus.LT24Reset_n = 1'b1;
      @(negedge clk); chk("panel_reset_cmdcode", cmdCode, 64'd0);
      bus_write(1'b1, 16'h9999, 1'b1);
      idle(2);
      cmd(8'h2C);
      exp_pix(8'd0, 9'd0, 16'h6666, 1'b0); bus_write(1'b1, 16'h6666, 1'b1);
      idle(2);

      // Wr_n and Rd_n low together; the data write that follows is ignored in OTHER
      cmd(8'h29);
      exp_perr();
      @(posedge clk); #1;
      bus.LT24CS_n = 1'b0; bus.LT24Wr_n = 1'b0; bus.LT24Rd_n = 1'b0;
      bus.LT24RS = 1'b1; bus.LT24Data = 16'hDEAD;
      @(posedge clk); #1;
      bus.LT24Wr_n = 1'b1; bus.LT24Rd_n = 1'b1; bus.LT24CS_n = 1'b1;
      idle(2);

      // CS_n rising with Wr_n still commits
      exp_cmd(8'h2C); bus_write(1'b0, 16'h002C, 1'b0);
      exp_pix(8'd0, 9'd0, 16'hCAFE, 1'b0); bus_write(1'b1, 16'hCAFE, 1'b0);
      exp_pix(8'd1, 9'd0, 16'h1234, 1'b0); bus_write(1'b1, 16'h1234, 1'b0);
      idle(2);

      // Asynchronous global reset mid-stream
      @(negedge clk); chk("pre_reset_display", displayOn, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {cmdValid, pixelValid, frameDone, displayOn, protocolError, cmdCode, pixelX, pixelY, pixelColour},
          64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      bus_write(1'b1, 16'h4321, 1'b1);
      idle(3);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
